// File: rtl/subgraph_feature_scatter_pkg.sv
// Shared types and helpers for the subgraph feature scatter engine:
// FSM state encoding, index-entry layout and quantiser saturation bounds.
package subgraph_feature_scatter_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_FEAT = 3'd1,
    FETCH_IDX = 3'd2,
    WRITE     = 3'd3,
    DONE      = 3'd4
  } state_e;

  // The idx field is wide enough for any node count; unused upper bits are zero.
  localparam int ENTRY_IDX_W = 32;

  typedef struct packed {
    logic                   sog;
    logic [ENTRY_IDX_W-1:0] idx;
    logic                   eog;
  } entry_t;

  function automatic int width_of(input int depth);
    if (depth > 1) begin
      return $clog2(depth);
    end else begin
      return 1;
    end
  endfunction

  function automatic longint q_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic longint q_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/feat_quantizer.sv
// Combinational quantiser: arithmetic right shift followed by saturation
// into the signed range of the narrow H data word.
module feat_quantizer
  import subgraph_feature_scatter_pkg::*;
#(
  parameter int IN_W  = 32,
  parameter int OUT_W = 8,
  parameter int SHIFT = 18
) (
  input  logic signed [IN_W-1:0]  feat_word,
  output logic signed [OUT_W-1:0] q_word
);

  localparam logic signed [IN_W-1:0] MAX_C = IN_W'(q_max(OUT_W));
  localparam logic signed [IN_W-1:0] MIN_C = IN_W'(q_min(OUT_W));

  logic signed [IN_W-1:0] shifted_s;

  // Shift then clamp to the representable output range
  always_comb begin
    shifted_s = feat_word >>> SHIFT;
    if (shifted_s > MAX_C) begin
      q_word = MAX_C[OUT_W-1:0];
    end else if (shifted_s < MIN_C) begin
      q_word = MIN_C[OUT_W-1:0];
    end else begin
      q_word = shifted_s[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/subgraph_feature_scatter.sv
// Scatters each subgraph's quantised feature vector to every node listed
// for it in the subgraph index BRAM, writing into the H data BRAM.
module subgraph_feature_scatter
  import subgraph_feature_scatter_pkg::*;
#(
  parameter int NUM_FEATURE_OUT   = 16,
  parameter int NEW_FEATURE_WIDTH = 32,
  parameter int H_DATA_WIDTH      = 8,
  parameter int QUANT_SHIFT       = 18,
  parameter int NUM_SUBGRAPHS     = 2708,
  parameter int TOTAL_NODES       = 13264,
  parameter int RD_LATENCY        = 1,
  localparam int FEAT_AW = width_of(NUM_SUBGRAPHS * NUM_FEATURE_OUT),
  localparam int IDX_W   = width_of(TOTAL_NODES),
  localparam int H_AW    = width_of(TOTAL_NODES * NUM_FEATURE_OUT)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         err_o,
  output logic [FEAT_AW-1:0]           feat_bram_addrb,
  input  logic [NEW_FEATURE_WIDTH-1:0] feat_bram_dout,
  output logic [IDX_W-1:0]             subgraph_bram_addrb,
  input  logic [IDX_W+1:0]             subgraph_bram_dout,
  output logic [H_AW-1:0]              h_data_bram_addra,
  output logic [H_DATA_WIDTH-1:0]      h_data_bram_din,
  output logic                         h_data_bram_ena,
  output logic                         h_data_bram_wea,
  input  logic                         h_data_bram_rdy
);

  localparam int NF        = NUM_FEATURE_OUT;
  localparam int KW        = width_of(NF);
  localparam int SW        = width_of(NUM_SUBGRAPHS);
  localparam int PW        = IDX_W + 1;
  localparam int CW        = width_of(NF + RD_LATENCY + 1);
  localparam int LOAD_LAST = NF + RD_LATENCY - 1;

  state_e state_r, state_nx_s;

  logic [CW-1:0]                       cyc_r;
  logic [SW-1:0]                       s_r;
  logic [PW-1:0]                       p_r;
  logic [KW-1:0]                       k_r;
  logic [RD_LATENCY-1:0]               vld_r;
  logic signed [NEW_FEATURE_WIDTH-1:0] feat_buf_r [NF];
  logic                                eog_r;
  logic                                first_entry_r;
  logic                                busy_r;
  logic                                done_r;
  logic                                err_r;
  logic [FEAT_AW-1:0]                  feat_addr_r;
  logic [H_AW-1:0]                     h_addr_r;
  logic [H_DATA_WIDTH-1:0]             h_din_r;
  logic                                h_en_r;

  entry_t                              entry_s;
  logic                                cap_s;
  logic                                p_wrap_s;
  logic                                subg_last_s;
  logic                                last_wr_s;
  logic                                start_acc_s;
  logic                                issue_s;
  logic                                feat_cap_s;
  logic                                idx_cap_s;
  logic                                wr_acc_s;
  logic                                entry_err_s;
  logic [KW-1:0]                       q_sel_s;
  logic [KW-1:0]                       buf_wr_sel_s;
  logic signed [NEW_FEATURE_WIDTH-1:0] q_in_s;
  logic signed [H_DATA_WIDTH-1:0]      q_out_s;

  assign cap_s        = vld_r[RD_LATENCY-1];
  assign entry_s      = '{sog: subgraph_bram_dout[IDX_W+1],
                          idx: ENTRY_IDX_W'(subgraph_bram_dout[IDX_W:1]),
                          eog: subgraph_bram_dout[0]};
  assign p_wrap_s     = (p_r + PW'(1)) == PW'(TOTAL_NODES);
  assign subg_last_s  = s_r == SW'(NUM_SUBGRAPHS - 1);
  assign last_wr_s    = k_r == KW'(NF - 1);
  assign entry_err_s  = first_entry_r ? !entry_s.sog : entry_s.sog;
  assign buf_wr_sel_s = KW'(cyc_r - CW'(RD_LATENCY));
  assign q_in_s       = feat_buf_r[q_sel_s];

  feat_quantizer #(
    .IN_W  (NEW_FEATURE_WIDTH),
    .OUT_W (H_DATA_WIDTH),
    .SHIFT (QUANT_SHIFT)
  ) u_quant (
    .feat_word (q_in_s),
    .q_word    (q_out_s)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_i) state_nx_s = LOAD_FEAT;
        else         state_nx_s = IDLE;
      end
      LOAD_FEAT: begin
        if (cyc_r == CW'(LOAD_LAST)) state_nx_s = FETCH_IDX;
        else                         state_nx_s = LOAD_FEAT;
      end
      FETCH_IDX: begin
        if (cap_s) state_nx_s = WRITE;
        else       state_nx_s = FETCH_IDX;
      end
      WRITE: begin
        if (h_data_bram_rdy && last_wr_s) begin
          if (p_wrap_s)         state_nx_s = DONE;
          else if (!eog_r)      state_nx_s = FETCH_IDX;
          else if (subg_last_s) state_nx_s = DONE;
          else                  state_nx_s = LOAD_FEAT;
        end else begin
          state_nx_s = WRITE;
        end
      end
      DONE:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // Per-state control strobes
  always_comb begin
    start_acc_s = 1'b0;
    issue_s     = 1'b0;
    feat_cap_s  = 1'b0;
    idx_cap_s   = 1'b0;
    wr_acc_s    = 1'b0;
    case (state_r)
      IDLE:      start_acc_s = start_i;
      LOAD_FEAT: begin
        issue_s    = cyc_r < CW'(NF);
        feat_cap_s = cap_s;
      end
      FETCH_IDX: begin
        issue_s   = cyc_r == CW'(0);
        idx_cap_s = cap_s;
      end
      WRITE:     wr_acc_s = h_data_bram_rdy;
      default:   start_acc_s = 1'b0;
    endcase
  end

  // Quantiser looks one word ahead so the registered din is ready on advance
  always_comb begin
    if (state_r == WRITE && !last_wr_s) begin
      q_sel_s = k_r + KW'(1);
    end else begin
      q_sel_s = KW'(0);
    end
  end

  // Read-capture valid pipeline matching the BRAM read latency
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_r <= {RD_LATENCY{1'b0}};
    end else begin
      vld_r[0] <= issue_s;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_r[i] <= vld_r[i-1];
      end
    end
  end

  // Counters, feature buffer and registered BRAM/status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_r         <= CW'(0);
      s_r           <= SW'(0);
      p_r           <= PW'(0);
      k_r           <= KW'(0);
      eog_r         <= 1'b0;
      first_entry_r <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      err_r         <= 1'b0;
      feat_addr_r   <= FEAT_AW'(0);
      h_addr_r      <= H_AW'(0);
      h_din_r       <= H_DATA_WIDTH'(0);
      h_en_r        <= 1'b0;
      for (int i = 0; i < NF; i++) begin
        feat_buf_r[i] <= NEW_FEATURE_WIDTH'(0);
      end
    end else begin
      if (state_nx_s != state_r) begin
        cyc_r <= CW'(0);
      end else if (state_r == LOAD_FEAT || state_r == FETCH_IDX) begin
        cyc_r <= cyc_r + CW'(1);
      end else begin
        cyc_r <= cyc_r;
      end

      if (start_acc_s) begin
        s_r           <= SW'(0);
        p_r           <= PW'(0);
        feat_addr_r   <= FEAT_AW'(0);
        first_entry_r <= 1'b1;
        err_r         <= 1'b0;
        busy_r        <= 1'b1;
      end

      if (issue_s && state_r == LOAD_FEAT && cyc_r < CW'(NF - 1)) begin
        feat_addr_r <= feat_addr_r + FEAT_AW'(1);
      end

      if (feat_cap_s) begin
        feat_buf_r[buf_wr_sel_s] <= feat_bram_dout;
      end

      if (idx_cap_s) begin
        eog_r         <= entry_s.eog;
        first_entry_r <= 1'b0;
        if (entry_err_s) err_r <= 1'b1;
        h_addr_r      <= H_AW'(entry_s.idx * ENTRY_IDX_W'(NF));
        h_din_r       <= q_out_s;
        h_en_r        <= 1'b1;
        k_r           <= KW'(0);
      end

      if (wr_acc_s) begin
        if (last_wr_s) begin
          h_en_r <= 1'b0;
          k_r    <= KW'(0);
          p_r    <= p_r + PW'(1);
          if (!p_wrap_s && eog_r && !subg_last_s) begin
            s_r           <= s_r + SW'(1);
            feat_addr_r   <= FEAT_AW'((32'(s_r) + 32'd1) * NF);
            first_entry_r <= 1'b1;
          end
        end else begin
          k_r      <= k_r + KW'(1);
          h_addr_r <= h_addr_r + H_AW'(1);
          h_din_r  <= q_out_s;
        end
      end

      done_r <= state_nx_s == DONE;
      if (state_r == DONE) busy_r <= 1'b0;
    end
  end

  assign busy_o              = busy_r;
  assign done_o              = done_r;
  assign err_o               = err_r;
  assign feat_bram_addrb     = feat_addr_r;
  assign subgraph_bram_addrb = p_r[IDX_W-1:0];
  assign h_data_bram_addra   = h_addr_r;
  assign h_data_bram_din     = h_din_r;
  assign h_data_bram_ena     = h_en_r;
  assign h_data_bram_wea     = h_en_r;

endmodule
